// File: rtl/cla_flow_alloc.sv
// -----------------------------------------------------------------------------
// cla_flow_alloc
//   Flow-entry allocator/releaser placed in front of the classifier flow free
//   list. Pops the free list's prefetched pointer for lookup-engine allocation
//   requests, round-robins pointer releases from the delete path (source 0)
//   and the aging engine (source 1) onto the single free-list release port,
//   sequences free-list re-initialisation and tracks the in-use entry count.
//
//   Optional build macro: CLA_FLOW_DBL_FREE_CHK_EN
//     Adds an in-use bitmap. A granted release of a pointer that is not
//     currently allocated is dropped and flagged on err_dbl_free.
//
// Ports
//   clk, rst_n (through `RESET_SIG)      clock, async active-low reset
//   flow_init / freeb_init               re-init request in / registered copy out
//   freeb_init_done                      free list finished initialising
//   freeb_empty, free_buf_ptr            free list prefetched head pointer
//   free_buf_rd                          pop the free list (combinational)
//   alloc_req / alloc_ack / alloc_nack   allocation handshake
//   alloc_ptr                            allocated pointer, valid with alloc_ack
//   del_valid/del_ptr/del_ready          release source 0
//   age_valid/age_ptr/age_ready          release source 1
//   rel_buf_valid / rel_buf_ptr          registered release to free list
//   flow_in_use                          allocated-entry count
//   err_underflow                        sticky: release seen at count 0
//   err_dbl_free                         (optional) one-cycle double-free flag
// -----------------------------------------------------------------------------
`ifndef FLOW_VALUE_DEPTH_NBITS
`define FLOW_VALUE_DEPTH_NBITS 4
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module cla_flow_alloc #(
  parameter int BPTR_NBITS     = `FLOW_VALUE_DEPTH_NBITS,
  parameter int WAIT_NBITS     = 8,
  parameter int ALLOC_WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  `RESET_SIG,
  input  logic                  flow_init,
  output logic                  freeb_init,
  input  logic                  freeb_init_done,
  input  logic                  freeb_empty,
  input  logic [BPTR_NBITS-1:0] free_buf_ptr,
  output logic                  free_buf_rd,
  input  logic                  alloc_req,
  output logic                  alloc_ack,
  output logic                  alloc_nack,
  output logic [BPTR_NBITS-1:0] alloc_ptr,
  input  logic                  del_valid,
  input  logic [BPTR_NBITS-1:0] del_ptr,
  output logic                  del_ready,
  input  logic                  age_valid,
  input  logic [BPTR_NBITS-1:0] age_ptr,
  output logic                  age_ready,
  output logic                  rel_buf_valid,
  output logic [BPTR_NBITS-1:0] rel_buf_ptr,
  output logic [BPTR_NBITS:0]   flow_in_use,
  output logic                  err_underflow
`ifdef CLA_FLOW_DBL_FREE_CHK_EN
  ,
  output logic                  err_dbl_free
`endif
);

  typedef enum logic [2:0] {INIT_FLUSH, INIT_WAIT, READY, WAIT_BUF, ACK} state_t;

  localparam logic [WAIT_NBITS-1:0] WAIT_MAX = WAIT_NBITS'(ALLOC_WAIT_MAX);
  localparam logic [WAIT_NBITS-1:0] WAIT_ONE = WAIT_NBITS'(1);
  localparam logic [BPTR_NBITS:0]   CNT_ONE  = (BPTR_NBITS + 1)'(1);

  state_t                  state_q, state_d;
  logic [WAIT_NBITS-1:0]   wait_q;
  logic                    init_nack_q;
  logic                    timeout_nack;
  logic                    buf_avail;
  logic                    rr_pri_q;     // 0: source 0 preferred, 1: source 1
  logic                    rel_open;
  logic                    grant;
  logic [BPTR_NBITS-1:0]   grant_ptr;
  logic                    rel_fwd;

  // A pointer may only be popped once the free list is out of initialisation.
  assign buf_avail = !freeb_empty && freeb_init_done;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    free_buf_rd  = 1'b0;
    timeout_nack = 1'b0;
    if (flow_init) begin
      state_d = INIT_FLUSH;
    end else begin
      case (state_q)
        INIT_FLUSH: if (!freeb_init_done) state_d = INIT_WAIT;
        INIT_WAIT:  if (freeb_init_done)  state_d = READY;
        READY: begin
          if (alloc_req) begin
            if (buf_avail) begin
              free_buf_rd = 1'b1;
              state_d     = ACK;
            end else begin
              state_d = WAIT_BUF;
            end
          end
        end
        WAIT_BUF: begin
          if (buf_avail) begin
            free_buf_rd = 1'b1;
            state_d     = ACK;
          end else if (wait_q == WAIT_MAX) begin
            timeout_nack = 1'b1;
            state_d      = READY;
          end
        end
        ACK:     state_d = READY;
        default: state_d = INIT_FLUSH;
      endcase
    end
  end

  assign alloc_ack  = (state_q == ACK);
  assign alloc_nack = init_nack_q | timeout_nack;

  // Releases are held off while the free list is (re)initialising and in the
  // cycle flow_init arrives, so nothing is written into a list being rebuilt.
  assign rel_open  = !flow_init && (state_q inside {READY, WAIT_BUF, ACK});
  assign del_ready = rel_open && del_valid && (!age_valid || !rr_pri_q);
  assign age_ready = rel_open && age_valid && (!del_valid ||  rr_pri_q);
  assign grant     = del_ready || age_ready;
  assign grant_ptr = del_ready ? del_ptr : age_ptr;

`ifdef CLA_FLOW_DBL_FREE_CHK_EN
  logic [2**BPTR_NBITS-1:0] in_use_map;

  assign rel_fwd = grant && in_use_map[grant_ptr];

  // NOTE: the bitmap is a flop vector, not a RAM, so it is reset here; its
  // all-zero state is what a freshly initialised free list implies.
  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      in_use_map   <= '0;
      err_dbl_free <= 1'b0;
    end else if (flow_init) begin
      in_use_map   <= '0;
      err_dbl_free <= 1'b0;
    end else begin
      if (alloc_ack) in_use_map[alloc_ptr] <= 1'b1;
      // Cleared at grant so a repeat release in the next cycle is caught.
      if (rel_fwd)   in_use_map[grant_ptr] <= 1'b0;
      err_dbl_free <= grant && !in_use_map[grant_ptr];
    end
  end
`else
  assign rel_fwd = grant;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge `RESET_SIG) begin
    if (!`RESET_SIG) begin
      state_q       <= INIT_FLUSH;
      wait_q        <= '0;
      init_nack_q   <= 1'b0;
      freeb_init    <= 1'b0;
      alloc_ptr     <= '0;
      rr_pri_q      <= 1'b0;
      rel_buf_valid <= 1'b0;
      rel_buf_ptr   <= '0;
      flow_in_use   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state_q     <= state_d;
      freeb_init  <= flow_init;
      // An ACK-state request is already served; anything else still waiting
      // is refused when the allocator is re-initialised.
      init_nack_q <= flow_init && alloc_req && (state_q != ACK);

      if (flow_init || state_q == READY)
        wait_q <= '0;
      else if (state_q == WAIT_BUF && wait_q != WAIT_MAX)
        wait_q <= wait_q + WAIT_ONE;

      if (free_buf_rd) alloc_ptr <= free_buf_ptr;

      if (grant) rr_pri_q <= ~rr_pri_q;
      rel_buf_valid <= rel_fwd;
      if (rel_fwd) rel_buf_ptr <= grant_ptr;

      if (flow_init) begin
        flow_in_use   <= '0;
        err_underflow <= 1'b0;
      end else if (rel_buf_valid && !alloc_ack) begin
        if (flow_in_use == '0) err_underflow <= 1'b1;
        else                   flow_in_use   <= flow_in_use - CNT_ONE;
      end else if (alloc_ack && !rel_buf_valid) begin
        flow_in_use <= flow_in_use + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/cla_flow_alloc.md
Name: cla_flow_alloc

Overview:
- Flow-entry allocator/releaser sitting directly in front of the classifier's flow free list.
- Serves allocation requests from the classifier lookup engine by popping the free list's prefetched pointer.
- Arbitrates pointer releases from two sources (classifier delete path, aging engine) onto the free list's single release port.
- Sequences free-list re-initialisation and keeps a live in-use count.

Parameters:
BPTR_NBITS, `FLOW_VALUE_DEPTH_NBITS, flow pointer width
WAIT_NBITS, 8, width of the allocation wait timer
ALLOC_WAIT_MAX, 255, empty-wait cycles before an allocation is refused (must fit WAIT_NBITS)

Ports:
clk  in  1  clock
`RESET_SIG  in  1  reset port declared through the codebase reset macro; asynchronous, active-low
flow_init  in  1  pulse: re-initialise free list and allocator
freeb_init  out  1  registered copy of flow_init to free list
freeb_init_done  in  1  free list initialised
freeb_empty  in  1  free list has no prefetched pointer
free_buf_ptr  in  BPTR_NBITS  free list head pointer (valid when !freeb_empty)
free_buf_rd  out  1  pop free list (combinational)
alloc_req  in  1  level request, held until ack or nack
alloc_ack  out  1  pulse: alloc_ptr valid
alloc_nack  out  1  pulse: allocation refused
alloc_ptr  out  BPTR_NBITS  allocated pointer
del_valid  in  1  release request, source 0 (delete)
del_ptr  in  BPTR_NBITS  release pointer, source 0
del_ready  out  1  source 0 accepted (combinational)
age_valid  in  1  release request, source 1 (aging)
age_ptr  in  BPTR_NBITS  release pointer, source 1
age_ready  out  1  source 1 accepted (combinational)
rel_buf_valid  out  1  release to free list (registered)
rel_buf_ptr  out  BPTR_NBITS  released pointer
flow_in_use  out  BPTR_NBITS+1  allocated-entry count
err_underflow  out  1  sticky: release while flow_in_use==0

Behaviour:
- Reset: all outputs 0; state INIT_FLUSH; round-robin priority to source 0.
- States: INIT_FLUSH, INIT_WAIT, READY, WAIT_BUF, ACK.
- INIT_FLUSH: proceed to INIT_WAIT once freeb_init_done==0.
- INIT_WAIT: proceed to READY once freeb_init_done==1.
- flow_init in any state:
  - freeb_init=1 next cycle; state -> INIT_FLUSH.
  - flow_in_use and timer cleared; err_underflow cleared.
  - Any pending alloc_req receives alloc_nack the next cycle.
- READY, alloc_req=1:
  - If !freeb_empty: free_buf_rd=1 this cycle, free_buf_ptr captured, state ACK.
  - If freeb_empty: timer cleared, state WAIT_BUF.
- WAIT_BUF:
  - free_buf_rd=1 when !freeb_empty, then state ACK.
  - Otherwise timer increments; at timer==ALLOC_WAIT_MAX, alloc_nack pulses and state returns READY.
- ACK: alloc_ack=1 with alloc_ptr for exactly one cycle, then READY.
  - Requester drops alloc_req in the ACK or NACK cycle; it is not sampled in ACK.
  - Latency: pop to ack is 1 cycle; maximum throughput is one allocation per 2 cycles.
- free_buf_rd never asserts outside READY/WAIT_BUF or while freeb_init_done==0.
- Releases:
  - Ready outputs are 0 outside READY/WAIT_BUF/ACK, so no writes occur during free-list init.
  - Otherwise round-robin between sources; one grant per cycle; a lone requester always wins; priority flips after each grant.
  - Granted pointer appears on rel_buf_ptr with rel_buf_valid=1 one cycle later.
- flow_in_use:
  - +1 on alloc_ack; -1 on rel_buf_valid; unchanged if both occur together.
  - Release at 0: count holds at 0 and err_underflow sets.

Optional Feature:
- CLA_FLOW_DBL_FREE_CHK_EN defined:
  - Adds a 2^BPTR_NBITS in-use bitmap, cleared by init; bit set on alloc_ack, cleared on release.
  - A granted release whose bit is already 0 is dropped: no rel_buf_valid, no count change; err_dbl_free pulses for 1 cycle.
  - Adds output port err_dbl_free (1 bit).
- Undefined: no bitmap; every granted release is forwarded; err_dbl_free port is absent.

Test Plan:
- Reset, then freeb_init_done 0->1 -> READY; one alloc_req with free_buf_ptr=5 -> free_buf_rd 1 cycle, alloc_ack next cycle with alloc_ptr=5, flow_in_use=1.
- freeb_empty=1 held, alloc_req high, ALLOC_WAIT_MAX=4 -> alloc_nack exactly 4 cycles after WAIT_BUF entry, free_buf_rd never asserted.
- del_valid and age_valid held for 4 cycles with ptrs 3 and 9 -> rel_buf_ptr sequence 3,9,3,9; flow_in_use decrements by 1 per release.
- alloc_ack coincides with rel_buf_valid -> flow_in_use unchanged; release while flow_in_use=0 -> err_underflow=1, count stays 0.
- flow_init during WAIT_BUF -> alloc_nack next cycle, freeb_init pulse, ready outputs 0 until freeb_init_done toggles 0->1.
- With CLA_FLOW_DBL_FREE_CHK_EN: allocate 7, release 7 twice -> first release forwarded, second gives err_dbl_free pulse and no rel_buf_valid.
